l1_read_arbiter: RTL and testbench

L1_READ_ARBITER -- requirements
Module: l1_read_arbiter

---
 rtl/l1_read_arbiter_pkg.sv | 32 +++
 rtl/l1_read_arbiter_if.sv | 56 +++++
 rtl/l1_read_arbiter_pick.sv | 35 +++
 rtl/l1_read_arbiter.sv | 156 +++++++++++++++
 tb/tb_l1_read_arbiter.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_read_arbiter_pkg.sv
// l1_read_arbiter_pkg
//   Shared types and constants for the L1 read arbiter slice.
//   arb_state_e : arbiter FSM encoding (IDLE=0, ADDR=1, DATA=2)
//   client_e    : requester id (ICACHE=0, DCACHE=1)
//   AXI_*       : fixed AXI read-address attributes used for line fills
//   line_align  : clears the word/offset bits of a byte address
package l1_read_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } client_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    // Zero the low (2 + offset_width) bits so the burst starts on a line boundary.
    function automatic logic [31:0] line_align(input logic [31:0] addr,
                                               input int unsigned offset_width);
        logic [31:0] mask;
        mask = '1;
        mask = mask << (offset_width + 2);
        return addr & mask;
    endfunction

endpackage

// File: rtl/l1_read_arbiter_if.sv
// l1_read_arbiter_if
//   Bundles both cache-client handshakes and the AXI read channels.
//   modport master : arbiter view (takes client requests, drives AR, accepts R)
//   modport slave  : environment view (caches and memory)
//   Client side : <c>_mem_req/<c>_mem_addr in, mem_<c>_grant/rvalid/rdata/rlast out
//   AXI side    : araddr/arlen/arsize/arburst/arvalid out, arready in,
//                 rdata/rvalid/rlast in, rready out
interface l1_read_arbiter_if;

    logic        icache_mem_req;
    logic [31:0] icache_mem_addr;
    logic        mem_icache_grant;
    logic        mem_icache_rvalid;
    logic [31:0] mem_icache_rdata;
    logic        mem_icache_rlast;

    logic        dcache_mem_req;
    logic [31:0] dcache_mem_addr;
    logic        mem_dcache_grant;
    logic        mem_dcache_rvalid;
    logic [31:0] mem_dcache_rdata;
    logic        mem_dcache_rlast;

    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic        rvalid;
    logic        rlast;
    logic        rready;

    modport master (
        input  icache_mem_req, icache_mem_addr, dcache_mem_req, dcache_mem_addr,
        output mem_icache_grant, mem_icache_rvalid, mem_icache_rdata, mem_icache_rlast,
        output mem_dcache_grant, mem_dcache_rvalid, mem_dcache_rdata, mem_dcache_rlast,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rvalid, rlast,
        output rready
    );

    modport slave (
        output icache_mem_req, icache_mem_addr, dcache_mem_req, dcache_mem_addr,
        input  mem_icache_grant, mem_icache_rvalid, mem_icache_rdata, mem_icache_rlast,
        input  mem_dcache_grant, mem_dcache_rvalid, mem_dcache_rdata, mem_dcache_rlast,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rvalid, rlast,
        input  rready
    );

endinterface

// File: rtl/l1_read_arbiter_pick.sv
// read_arb_pick
//   Chooses which cache wins the AXI read port when the arbiter is idle.
//   icache_req_i / dcache_req_i : pending requests
//   last_owner_i                : client that owned the previous burst
//   winner_o                    : selected client (only meaningful if a req is set)
//   Build option RR_ARB_EN: round-robin, the previous owner loses a tie.
//   Default build: dcache always wins a tie.
module read_arb_pick
    import l1_read_arbiter_pkg::*;
(
    input  logic    icache_req_i,
    input  logic    dcache_req_i,
    input  client_e last_owner_i,
    output client_e winner_o
);

`ifdef RR_ARB_EN
    always_comb begin
        winner_o = ICACHE;
        if (icache_req_i && dcache_req_i) begin
            winner_o = (last_owner_i == DCACHE) ? ICACHE : DCACHE;
        end else if (dcache_req_i) begin
            winner_o = DCACHE;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner_i;

    always_comb begin
        winner_o = dcache_req_i ? DCACHE : ICACHE;
    end
`endif

endmodule

// File: rtl/l1_read_arbiter.sv
// l1_read_arbiter
//   Shares one AXI read port between icache and dcache line fills; one
//   outstanding INCR burst of (1 << OFFSET_WIDTH) 32-bit beats at a time.
//   clk, rst : clock and synchronous active-high reset
//   bus      : l1_read_arbiter_if.master (client handshakes + AXI AR/R channels)
//   Build option RR_ARB_EN selects round-robin arbitration (see read_arb_pick).
module l1_read_arbiter
    import l1_read_arbiter_pkg::*;
#(
    parameter int unsigned OFFSET_WIDTH = 2
) (
    input logic                clk,
    input logic                rst,
    l1_read_arbiter_if.master  bus
);

    localparam int unsigned     BURST_LEN = 1 << OFFSET_WIDTH;
    localparam int unsigned     CNT_W     = OFFSET_WIDTH + 1;
    localparam logic [7:0]      ARLEN_VAL = 8'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_LEN);

    arb_state_e       state_q,    state_d;
    client_e          owner_q,    owner_d;
    client_e          winner;
    logic [31:0]      addr_q,     addr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             arvalid_q,  arvalid_d;
    logic [31:0]      araddr_q,   araddr_d;
    logic [7:0]       arlen_q,    arlen_d;
    logic [2:0]       arsize_q,   arsize_d;
    logic [1:0]       arburst_q,  arburst_d;
    logic             rready_q,   rready_d;

    logic ar_fire;
    logic fwd_icache;
    logic fwd_dcache;

    // The owner register also serves as the round-robin history.
    read_arb_pick u_pick (
        .icache_req_i (bus.icache_mem_req),
        .dcache_req_i (bus.dcache_mem_req),
        .last_owner_i (owner_q),
        .winner_o     (winner)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        beat_cnt_d = beat_cnt_q;
        arvalid_d  = arvalid_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        arsize_d   = arsize_q;
        arburst_d  = arburst_q;
        rready_d   = rready_q;

        case (state_q)
            IDLE: begin
                if (bus.icache_mem_req || bus.dcache_mem_req) begin
                    owner_d   = winner;
                    addr_d    = line_align((winner == DCACHE) ? bus.dcache_mem_addr
                                                              : bus.icache_mem_addr,
                                           OFFSET_WIDTH);
                    arvalid_d = 1'b1;
                    araddr_d  = addr_d;
                    arlen_d   = ARLEN_VAL;
                    arsize_d  = AXI_SIZE_4B;
                    arburst_d = AXI_BURST_INCR;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (bus.arready) begin
                    arvalid_d  = 1'b0;
                    araddr_d   = '0;
                    arlen_d    = '0;
                    arsize_d   = '0;
                    arburst_d  = '0;
                    rready_d   = 1'b1;
                    beat_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (bus.rvalid) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    // rlast ends the burst even if the beat count disagrees.
                    if (bus.rlast) begin
                        rready_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= ICACHE;
            addr_q     <= '0;
            beat_cnt_q <= '0;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arsize_q   <= '0;
            arburst_q  <= '0;
            rready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            beat_cnt_q <= beat_cnt_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            arsize_q   <= arsize_d;
            arburst_q  <= arburst_d;
            rready_q   <= rready_d;
        end
    end

    // A burst that runs past its nominal length means rlast went missing.
    always_ff @(posedge clk) begin
        if (!rst && state_q == DATA) begin
            assert (beat_cnt_q <= CNT_MAX);
        end
    end

    // rready_q is high exactly while in DATA, so it gates beat forwarding.
    assign ar_fire    = arvalid_q & bus.arready;
    assign fwd_icache = rready_q & bus.rvalid & (owner_q == ICACHE);
    assign fwd_dcache = rready_q & bus.rvalid & (owner_q == DCACHE);

    assign bus.mem_icache_grant  = ar_fire & (owner_q == ICACHE);
    assign bus.mem_dcache_grant  = ar_fire & (owner_q == DCACHE);

    assign bus.mem_icache_rvalid = fwd_icache;
    assign bus.mem_icache_rdata  = fwd_icache ? bus.rdata : '0;
    assign bus.mem_icache_rlast  = fwd_icache & bus.rlast;
    assign bus.mem_dcache_rvalid = fwd_dcache;
    assign bus.mem_dcache_rdata  = fwd_dcache ? bus.rdata : '0;
    assign bus.mem_dcache_rlast  = fwd_dcache & bus.rlast;

    assign bus.arvalid = arvalid_q;
    assign bus.araddr  = araddr_q;
    assign bus.arlen   = arlen_q;
    assign bus.arsize  = arsize_q;
    assign bus.arburst = arburst_q;
    assign bus.rready  = rready_q;

endmodule

// File: tb/tb_l1_read_arbiter.sv
// tb_l1_read_arbiter
//   Directed and randomized line-fill traffic against l1_read_arbiter.
//   Inputs are driven on the falling edge and outputs sampled 1 ns later.
//   The expected winner, line address and beat routing come from the
//   arbitration rules applied to the requests the bench itself raised.
module tb_l1_read_arbiter;

    localparam int OW    = 2;
    localparam int BURST = 1 << OW;

    logic clk = 1'b0;
    logic rst;

    int total = 0;
    int bad   = 0;

    bit last_dc = 1'b0;
    int ic_beats = 0;
    int dc_beats = 0;
    int exp_ic_beats = 0;
    int exp_dc_beats = 0;
    bit grant_log[$];

    l1_read_arbiter_if bus ();

    l1_read_arbiter #(.OFFSET_WIDTH(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_icache_rvalid) ic_beats++;
        if (bus.mem_dcache_rvalid) dc_beats++;
        if (bus.mem_icache_grant || bus.mem_dcache_grant) grant_log.push_back(bus.mem_dcache_grant);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 1 = dcache wins.
    function automatic bit model_pick(bit ireq, bit dreq, bit prev_dc);
`ifdef RR_ARB_EN
        if (ireq && dreq) return !prev_dc;
`else
        if (ireq && dreq) return 1'b1;
`endif
        return dreq;
    endfunction

    function automatic logic [31:0] line_of(logic [31:0] a);
        return a - (a % 32'(4 * BURST));
    endfunction

    // One burst from AR wait to the idle cycle after rlast.
    // gap < 0 : random 0..2 idle cycles before each beat; otherwise fixed gap
    // between beats. nbeats < BURST stops early without the final idle check.
    task automatic do_burst(input int ar_wait, input int gap, input bit viol,
                            input bit drop_early, input bit hold, input bit seq_data,
                            input int nbeats, output int lat);
        bit          exp_dc;
        bit          seen;
        bit          last;
        logic [31:0] exp_addr;
        logic [31:0] d;
        int          g;
        exp_dc   = model_pick(bus.icache_mem_req, bus.dcache_mem_req, last_dc);
        exp_addr = line_of(exp_dc ? bus.dcache_mem_addr : bus.icache_mem_addr);
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 8) begin
            @(negedge clk); #1;
            lat++;
            seen = bus.arvalid;
        end
        check("arvalid_seen", 32'(seen), 32'd1);
        if (!seen) return;
        check("araddr", bus.araddr, exp_addr);
        check("arlen", 32'(bus.arlen), 32'(BURST - 1));
        check("arsize", 32'(bus.arsize), 32'h2);
        check("arburst", 32'(bus.arburst), 32'h1);
        if (drop_early) begin
            if (exp_dc) bus.dcache_mem_req = 1'b0;
            else        bus.icache_mem_req = 1'b0;
        end
        for (int c = 0; c < ar_wait; c++) begin
            @(negedge clk);
            if (viol) begin
                bus.rvalid = 1'b1;
                bus.rdata  = $urandom;
                bus.rlast  = 1'($urandom_range(1, 0));
            end
            #1;
            check("ar_hold_addr", bus.araddr, exp_addr);
            check("ar_hold_flags", 32'({bus.arvalid, bus.rready, bus.mem_icache_grant,
                  bus.mem_dcache_grant, bus.mem_icache_rvalid, bus.mem_dcache_rvalid}),
                  32'(6'b100000));
        end
        @(negedge clk);
        bus.rvalid  = 1'b0;
        bus.rlast   = 1'b0;
        bus.arready = 1'b1;
        #1;
        check("grant", 32'({bus.mem_icache_grant, bus.mem_dcache_grant, bus.rready}),
              32'({!exp_dc, exp_dc, 1'b0}));
        if (!hold) begin
            if (exp_dc) bus.dcache_mem_req = 1'b0;
            else        bus.icache_mem_req = 1'b0;
        end
        last_dc = exp_dc;
        @(negedge clk);
        bus.arready = 1'b0;
        #1;
        check("data_entry", 32'({bus.arvalid, bus.rready, bus.mem_icache_grant, bus.mem_dcache_grant}),
              32'(4'b0100));
        for (int b = 0; b < nbeats; b++) begin
            g = (gap < 0) ? int'($urandom_range(2, 0)) : ((b == 0) ? 0 : gap);
            for (int k = 0; k < g; k++) begin
                @(negedge clk);
                bus.rvalid = 1'b0;
                bus.rlast  = 1'b0;
                bus.rdata  = $urandom;
                #1;
                check("gap_quiet", 32'({bus.mem_icache_rvalid, bus.mem_dcache_rvalid, bus.rready}),
                      32'(3'b001));
            end
            @(negedge clk);
            d    = seq_data ? (32'hA + 32'(b)) : $urandom;
            last = (b == BURST - 1);
            bus.rvalid = 1'b1;
            bus.rdata  = d;
            bus.rlast  = last;
            #1;
            check("beat_flags", 32'({bus.mem_icache_rvalid, bus.mem_icache_rlast, bus.mem_dcache_rvalid,
                  bus.mem_dcache_rlast, bus.rready}),
                  32'({!exp_dc, !exp_dc && last, exp_dc, exp_dc && last, 1'b1}));
            check("beat_owner_data", exp_dc ? bus.mem_dcache_rdata : bus.mem_icache_rdata, d);
            check("beat_other_data", exp_dc ? bus.mem_icache_rdata : bus.mem_dcache_rdata, 32'd0);
            if (exp_dc) exp_dc_beats++;
            else        exp_ic_beats++;
        end
        if (nbeats < BURST) return;
        @(negedge clk);
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        #1;
        check("idle_after_rlast", 32'({bus.rready, bus.arvalid, bus.mem_icache_rvalid, bus.mem_dcache_rvalid}),
              32'd0);
    endtask

    initial begin
        int         lat;
        int         ic0;
        int         dc0;
        logic [3:0] order;
        logic [3:0] exp_order;

        bus.icache_mem_req  = 1'b0;
        bus.icache_mem_addr = '0;
        bus.dcache_mem_req  = 1'b0;
        bus.dcache_mem_addr = '0;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = '0;
        bus.rlast   = 1'b0;
        rst = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_ctrl", 32'({bus.arvalid, bus.rready, bus.mem_icache_grant, bus.mem_dcache_grant}), 32'd0);
        check("rst_araddr", bus.araddr, 32'd0);
        check("rst_ar_fields", 32'({bus.arlen, bus.arsize, bus.arburst}), 32'd0);
        check("rst_client_flags", 32'({bus.mem_icache_rvalid, bus.mem_icache_rlast,
              bus.mem_dcache_rvalid, bus.mem_dcache_rlast}), 32'd0);
        check("rst_client_data", bus.mem_icache_rdata | bus.mem_dcache_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single icache fill, AR accepted after two wait cycles, beats A..D
        ic0 = ic_beats; dc0 = dc_beats;
        bus.icache_mem_addr = 32'h0000_1234;
        bus.icache_mem_req  = 1'b1;
        do_burst(2, 0, 1'b0, 1'b0, 1'b0, 1'b1, BURST, lat);
        check("fill_ic_beats", 32'(ic_beats - ic0), 32'(BURST));
        check("fill_dc_beats", 32'(dc_beats - dc0), 32'd0);

        // Simultaneous requests: dcache first, icache starts right after
        bus.icache_mem_addr = $urandom;
        bus.dcache_mem_addr = $urandom;
        bus.icache_mem_req  = 1'b1;
        bus.dcache_mem_req  = 1'b1;
        grant_log.delete();
        do_burst(1, 0, 1'b0, 1'b0, 1'b0, 1'b0, BURST, lat);
        do_burst(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, BURST, lat);
        check("tie_second_latency", 32'(lat), 32'd1);
        check("tie_first_dcache", 32'(grant_log.size() == 2 ? grant_log[0] : 1'bx), 32'd1);

        // Both clients requesting continuously for four bursts
        bus.icache_mem_req = 1'b1;
        bus.dcache_mem_req = 1'b1;
        grant_log.delete();
        for (int n = 0; n < 4; n++) begin
            do_burst(int'($urandom_range(2, 0)), -1, 1'b0, 1'b0, 1'b1, 1'b0, BURST, lat);
            if (n > 0) check("cont_latency", 32'(lat), 32'd1);
        end
        bus.icache_mem_req = 1'b0;
        bus.dcache_mem_req = 1'b0;
        order = '0;
        foreach (grant_log[i]) order = {order[2:0], grant_log[i]};
        check("cont_grant_count", 32'(grant_log.size()), 32'd4);
`ifdef RR_ARB_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b1111;
`endif
        check("cont_grant_order", 32'(order), 32'(exp_order));

        // Three idle cycles between beats
        bus.icache_mem_addr = $urandom;
        bus.icache_mem_req  = 1'b1;
        do_burst(0, 3, 1'b0, 1'b0, 1'b0, 1'b0, BURST, lat);

        // Stray rvalid while the address is still pending
        bus.dcache_mem_addr = $urandom;
        bus.dcache_mem_req  = 1'b1;
        do_burst(3, 0, 1'b1, 1'b0, 1'b0, 1'b0, BURST, lat);

        // Request withdrawn after latching still completes
        bus.icache_mem_addr = $urandom;
        bus.icache_mem_req  = 1'b1;
        do_burst(2, 0, 1'b0, 1'b1, 1'b0, 1'b0, BURST, lat);

        // Reset during the second beat, then leftover beats from memory
        bus.icache_mem_addr = $urandom;
        bus.icache_mem_req  = 1'b1;
        do_burst(1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1, lat);
        @(negedge clk);
        bus.rvalid = 1'b1;
        bus.rdata  = $urandom;
        bus.rlast  = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_beat_still_fwd", 32'(bus.mem_icache_rvalid), 32'd1);
        exp_ic_beats++;
        @(negedge clk);
        rst = 1'b0;
        bus.rdata = $urandom;
        #1;
        check("stray_beat1", 32'({bus.mem_icache_rvalid, bus.mem_dcache_rvalid, bus.rready, bus.arvalid}), 32'd0);
        @(negedge clk);
        bus.rdata = $urandom;
        bus.rlast = 1'b1;
        #1;
        check("stray_beat2", 32'({bus.mem_icache_rvalid, bus.mem_dcache_rvalid, bus.rready, bus.arvalid}), 32'd0);
        check("stray_data", bus.mem_icache_rdata | bus.mem_dcache_rdata, 32'd0);
        @(negedge clk);
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        last_dc    = 1'b0;
        bus.dcache_mem_addr = $urandom;
        bus.dcache_mem_req  = 1'b1;
        do_burst(1, 0, 1'b0, 1'b0, 1'b0, 1'b0, BURST, lat);

        // Random traffic
        for (int it = 0; it < 16; it++) begin
            if (!bus.icache_mem_req && $urandom_range(1, 0) == 1) begin
                bus.icache_mem_addr = $urandom;
                bus.icache_mem_req  = 1'b1;
            end
            if (!bus.dcache_mem_req && ($urandom_range(1, 0) == 1 || !bus.icache_mem_req)) begin
                bus.dcache_mem_addr = $urandom;
                bus.dcache_mem_req  = 1'b1;
            end
            do_burst(int'($urandom_range(3, 0)), -1, 1'($urandom_range(1, 0)), 1'b0, 1'b0, 1'b0, BURST, lat);
        end

        check("total_ic_beats", 32'(ic_beats), 32'(exp_ic_beats));
        check("total_dc_beats", 32'(dc_beats), 32'(exp_dc_beats));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
